om_ds_writeback: RTL and testbench

Writeback stage directly downstream of the OM depth/stencil test. It accepts tested fragments (depth, stencil, pass per lane) and packs each lane into a 32-bit depth/stencil word with byte enables. It issues a posted memory write for the lanes that actually change storage, and forwards the per-lane pass mask and tag to the blend/retire path. It also tracks outstanding writes so the OM can drain before a flush.

---
 rtl/om_ds_writeback_pkg.sv | 29 ++
 rtl/om_ds_writeback_pending_counter.sv | 31 +++
 rtl/om_ds_writeback.sv | 151 +++++++++++++++
 tb/tb_om_ds_writeback.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/om_ds_writeback_pkg.sv
// Shared types and helpers for the OM depth/stencil writeback stage.
// Holds the OM control-register view and the per-lane byte-enable rule.
package om_ds_writeback_pkg;

    localparam int VX_OM_DEPTH_BITS   = 24;
    localparam int VX_OM_STENCIL_BITS = 8;
    localparam int OM_DS_WORD_BITS    = 32;

    typedef struct packed {
        logic                                   depth_writemask;
        logic [1:0][VX_OM_STENCIL_BITS-1:0]     stencil_writemask;
    } om_dcrs_t;

    // Stencil byte is written even on a failed test: the stencil op
    // still applies to failing fragments.
    function automatic logic [3:0] om_ds_byteen(
        input logic     mask,
        input logic     pass,
        input logic     face,
        input om_dcrs_t dcrs
    );
        logic w_z;
        logic w_s;
        w_z = mask & pass & dcrs.depth_writemask;
        w_s = mask & (dcrs.stencil_writemask[face] != '0);
        return {w_s, {3{w_z}}};
    endfunction

endpackage

// File: rtl/om_ds_writeback_pending_counter.sv
// Up/down counter of posted writes awaiting acknowledge.
// Simultaneous increment and decrement leave the count unchanged.
module om_ds_pending_counter #(
    parameter int MAX_PENDING = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_incr,
    input  logic i_decr,
    output logic o_full,
    output logic o_empty
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_incr && !i_decr && !o_full) begin
            r_count <= r_count + 1'b1;
        end else if (!i_incr && i_decr && !o_empty) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_full  = (r_count == CNT_W'(MAX_PENDING));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/om_ds_writeback.sv
// OM depth/stencil writeback: packs tested lanes into posted memory
// writes and forwards the pass mask, tracking unacknowledged writes.
module om_ds_writeback
    import om_ds_writeback_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int TAG_WIDTH   = 1,
    parameter int ADDR_WIDTH  = 30,
    parameter int MAX_PENDING = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  om_dcrs_t                                       dcrs,
    input  logic                                           valid_in,
    output logic                                           ready_in,
    input  logic [TAG_WIDTH-1:0]                           tag_in,
    input  logic [NUM_LANES-1:0]                           mask_in,
    input  logic [NUM_LANES-1:0]                           face_in,
    input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]           addr_in,
    input  logic [NUM_LANES-1:0][VX_OM_DEPTH_BITS-1:0]     depth_in,
    input  logic [NUM_LANES-1:0][VX_OM_STENCIL_BITS-1:0]   stencil_in,
    input  logic [NUM_LANES-1:0]                           pass_in,
    output logic                                           mem_req_valid,
    input  logic                                           mem_req_ready,
    output logic [NUM_LANES-1:0]                           mem_req_mask,
    output logic [NUM_LANES-1:0][3:0]                      mem_req_byteen,
    output logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]           mem_req_addr,
    output logic [NUM_LANES-1:0][OM_DS_WORD_BITS-1:0]      mem_req_data,
    output logic [TAG_WIDTH-1:0]                           mem_req_tag,
    input  logic                                           mem_rsp_valid,
    output logic                                           mem_rsp_ready,
    output logic                                           valid_out,
    input  logic                                           ready_out,
    output logic [TAG_WIDTH-1:0]                           tag_out,
    output logic [NUM_LANES-1:0]                           pass_out,
    output logic                                           busy
);

    logic                                       r_valid;
    logic                                       r_mem_done;
    logic                                       r_out_done;
    logic [TAG_WIDTH-1:0]                       r_tag;
    logic [NUM_LANES-1:0]                       r_pass;
    logic [NUM_LANES-1:0][3:0]                  r_byteen;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]       r_addr;
    logic [NUM_LANES-1:0][OM_DS_WORD_BITS-1:0]  r_data;

    logic                                       w_load;
    logic                                       w_mem_fire;
    logic                                       w_out_fire;
    logic                                       w_rsp_fire;
    logic                                       w_retire;
    logic                                       w_full;
    logic                                       w_empty;
    logic                                       w_has_write;
    logic [NUM_LANES-1:0][3:0]                  w_byteen;
    logic [NUM_LANES-1:0][OM_DS_WORD_BITS-1:0]  w_data;

    always_comb begin
        w_byteen = '0;
        w_data   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_byteen[i] = om_ds_byteen(mask_in[i], pass_in[i],
                                       face_in[i], dcrs);
            w_data[i]   = {stencil_in[i], depth_in[i]};
        end
    end

    assign w_has_write = |w_byteen;

    // Memory and completion sides fork; the entry retires once both
    // have been accepted, possibly in the same cycle.
    assign mem_req_valid = r_valid & ~r_mem_done & ~w_full;
    assign valid_out     = r_valid & ~r_out_done;
    assign w_mem_fire    = mem_req_valid & mem_req_ready;
    assign w_out_fire    = valid_out & ready_out;
    assign w_rsp_fire    = mem_rsp_valid & mem_rsp_ready;
    assign w_retire      = r_valid
                         & (r_mem_done | w_mem_fire)
                         & (r_out_done | w_out_fire);
    assign ready_in      = ~r_valid | w_retire;
    assign w_load        = valid_in & ready_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_mem_done <= 1'b0;
            r_out_done <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_mem_done <= ~w_has_write;
            r_out_done <= 1'b0;
        end else if (w_retire) begin
            r_valid    <= 1'b0;
            r_mem_done <= 1'b0;
            r_out_done <= 1'b0;
        end else begin
            if (w_mem_fire) r_mem_done <= 1'b1;
            if (w_out_fire) r_out_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag    <= '0;
            r_pass   <= '0;
            r_byteen <= '0;
            r_addr   <= '0;
            r_data   <= '0;
        end else if (w_load) begin
            r_tag    <= tag_in;
            r_pass   <= mask_in & pass_in;
            r_byteen <= w_byteen;
            r_addr   <= addr_in;
            r_data   <= w_data;
        end
    end

    om_ds_pending_counter #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pending (
        .clk     (clk),
        .reset   (reset),
        .i_incr  (w_mem_fire),
        .i_decr  (w_rsp_fire),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        mem_req_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mem_req_mask[i] = |r_byteen[i];
        end
    end

    assign mem_req_byteen = r_byteen;
    assign mem_req_addr   = r_addr;
    assign mem_req_data   = r_data;
    assign mem_req_tag    = r_tag;
    assign mem_rsp_ready  = 1'b1;
    assign tag_out        = r_tag;
    assign pass_out       = r_pass;
    assign busy           = r_valid | ~w_empty;

    a_rsp_underflow: assert property (
        @(posedge clk) disable iff (!reset)
        mem_rsp_valid |-> !w_empty
    );

endmodule

// File: tb/tb_om_ds_writeback.sv
// Bench for om_ds_writeback: vector table, directed corner sequences
// and random traffic against a queue-based transaction model.
module tb_om_ds_writeback;
    import om_ds_writeback_pkg::*;

    localparam int NL   = 4;
    localparam int TW   = 1;
    localparam int AW   = 30;
    localparam int MAXP = 8;

    logic                   clk;
    logic                   reset;
    om_dcrs_t               dcrs;
    logic                   valid_in;
    logic                   ready_in;
    logic [TW-1:0]          tag_in;
    logic [NL-1:0]          mask_in;
    logic [NL-1:0]          face_in;
    logic [NL-1:0][AW-1:0]  addr_in;
    logic [NL-1:0][23:0]    depth_in;
    logic [NL-1:0][7:0]     stencil_in;
    logic [NL-1:0]          pass_in;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [NL-1:0]          mem_req_mask;
    logic [NL-1:0][3:0]     mem_req_byteen;
    logic [NL-1:0][AW-1:0]  mem_req_addr;
    logic [NL-1:0][31:0]    mem_req_data;
    logic [TW-1:0]          mem_req_tag;
    logic                   mem_rsp_valid;
    logic                   mem_rsp_ready;
    logic                   valid_out;
    logic                   ready_out;
    logic [TW-1:0]          tag_out;
    logic [NL-1:0]          pass_out;
    logic                   busy;

    om_ds_writeback #(
        .NUM_LANES(NL), .TAG_WIDTH(TW),
        .ADDR_WIDTH(AW), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset(reset), .dcrs(dcrs),
        .valid_in(valid_in), .ready_in(ready_in),
        .tag_in(tag_in), .mask_in(mask_in),
        .face_in(face_in), .addr_in(addr_in),
        .depth_in(depth_in), .stencil_in(stencil_in),
        .pass_in(pass_in),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_mask(mem_req_mask),
        .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data),
        .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_ready(mem_rsp_ready),
        .valid_out(valid_out), .ready_out(ready_out),
        .tag_out(tag_out), .pass_out(pass_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NL*4-1:0]  be;
        logic [NL*32-1:0] data;
        logic [NL*AW-1:0] addr;
        logic [TW-1:0]    tag;
    } mexp_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [NL-1:0] pass;
    } oexp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  pass;
        logic [3:0]  face;
        logic        dwm;
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [15:0] be;
        logic [3:0]  po;
    } vec_t;

    mexp_t mq[$];
    oexp_t oq[$];
    vec_t  vt[6];
    int    checks   = 0;
    int    failures = 0;
    int    pend     = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Depth bytes need a passing active lane with depth writes on;
    // the stencil byte needs only an active lane and a nonzero mask
    // for the lane's face.
    function automatic logic [NL*4-1:0] model_be(
        input logic [NL-1:0] m, input logic [NL-1:0] p,
        input logic [NL-1:0] f, input om_dcrs_t d);
        logic [NL*4-1:0] be;
        logic [7:0]      swm;
        be = '0;
        for (int i = 0; i < NL; i++) begin
            swm = f[i] ? d.stencil_writemask[1]
                       : d.stencil_writemask[0];
            if (m[i] && p[i] && d.depth_writemask)
                be[i*4 +: 3] = 3'b111;
            be[i*4+3] = m[i] && (swm != 8'd0);
        end
        return be;
    endfunction

    function automatic logic [NL-1:0] lanes_of(input logic [NL*4-1:0] be);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = (be[i*4 +: 4] != 4'd0);
        return r;
    endfunction

    task automatic step();
        mexp_t m;
        oexp_t o;
        logic  acc, mf, of, rf;
        #3;
        acc = valid_in && ready_in;
        mf  = mem_req_valid && mem_req_ready;
        of  = valid_out && ready_out;
        rf  = mem_rsp_valid;
        chk("pend_limit", mem_req_valid && pend >= MAXP, 0);
        if (mf) begin
            if (mq.size() == 0) chk("mem_unexpected", 1, 0);
            else begin
                m = mq.pop_front();
                chk("mem_byteen", mem_req_byteen, m.be);
                chk("mem_mask", mem_req_mask, lanes_of(m.be));
                chk("mem_data", mem_req_data, m.data);
                chk("mem_addr", mem_req_addr, m.addr);
                chk("mem_tag", mem_req_tag, m.tag);
            end
        end
        if (of) begin
            if (oq.size() == 0) chk("out_unexpected", 1, 0);
            else begin
                o = oq.pop_front();
                chk("out_tag", tag_out, o.tag);
                chk("out_pass", pass_out, o.pass);
            end
        end
        if (acc) begin
            m.be = model_be(mask_in, pass_in, face_in, dcrs);
            for (int i = 0; i < NL; i++) begin
                m.data[i*32 +: 32] = {stencil_in[i], depth_in[i]};
                m.addr[i*AW +: AW] = addr_in[i];
            end
            m.tag = tag_in;
            if (m.be != '0) mq.push_back(m);
            o.tag  = tag_in;
            o.pass = mask_in & pass_in;
            oq.push_back(o);
        end
        @(posedge clk);
        #1;
        pend = pend + (mf ? 1 : 0) - (rf ? 1 : 0);
    endtask

    task automatic set_vec(input vec_t v, input logic [TW-1:0] t);
        mask_in = v.mask;
        pass_in = v.pass;
        face_in = v.face;
        dcrs.depth_writemask      = v.dwm;
        dcrs.stencil_writemask[0] = v.s0;
        dcrs.stencil_writemask[1] = v.s1;
        tag_in = t;
        for (int i = 0; i < NL; i++) begin
            depth_in[i]   = 24'h123456 + 24'(i * 'h1111);
            stencil_in[i] = 8'hA5 ^ 8'(i);
            addr_in[i]    = AW'(100 + i);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (!busy && pend == 0) break;
            valid_in      = 1'b0;
            ready_out     = 1'b1;
            mem_req_ready = 1'b1;
            mem_rsp_valid = (pend > 0);
            step();
        end
        mem_rsp_valid = 1'b0;
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'h1, 4'h1, 4'h0, 1'b1, 8'hFF, 8'h00, 16'h000F, 4'h1};
        vt[1] = '{4'hF, 4'h0, 4'h0, 1'b1, 8'h00, 8'h00, 16'h0000, 4'h0};
        vt[2] = '{4'hF, 4'h0, 4'h0, 1'b1, 8'h0F, 8'h00, 16'h8888, 4'h0};
        vt[3] = '{4'hF, 4'hF, 4'h0, 1'b0, 8'h00, 8'h00, 16'h0000, 4'hF};
        vt[4] = '{4'hA, 4'h6, 4'hC, 1'b1, 8'h00, 8'h01, 16'h8070, 4'h2};
        vt[5] = '{4'hF, 4'h5, 4'h3, 1'b1, 8'hFF, 8'h00, 16'h8F07, 4'h5};

        reset = 1'b0;
        dcrs = '0;
        valid_in = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        ready_out = 1'b0;
        set_vec(vt[0], 1'b0);
        #2;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_mem_rsp_ready", mem_rsp_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int k = 0; k < 6; k++) begin
            set_vec(vt[k], TW'(k));
            valid_in = 1'b1;
            mem_req_ready = 1'b1;
            ready_out = 1'b1;
            step();
            valid_in = 1'b0;
            chk("tv_byteen", mem_req_byteen, vt[k].be);
            chk("tv_mreq_valid", mem_req_valid, |vt[k].be);
            chk("tv_mem_mask", mem_req_mask, lanes_of(vt[k].be));
            chk("tv_valid_out", valid_out, 1);
            chk("tv_pass_out", pass_out, vt[k].po);
            chk("tv_data0", mem_req_data[0], 32'hA5123456);
            step();
            chk("tv_retired", valid_out, 0);
            chk("tv_busy", busy, |vt[k].be);
            drain();
        end

        // Completion stalled while the write goes out.
        set_vec(vt[0], 1'b1);
        valid_in = 1'b1;
        ready_out = 1'b0;
        mem_req_ready = 1'b1;
        step();
        valid_in = 1'b0;
        chk("st_mem_valid", mem_req_valid, 1);
        chk("st_valid_out", valid_out, 1);
        step();
        chk("st_mem_sent", mem_req_valid, 0);
        chk("st_hold_valid", valid_out, 1);
        chk("st_hold_ready_in", ready_in, 0);
        step();
        step();
        chk("st_tag_stable", tag_out, 1);
        chk("st_pass_stable", pass_out, 4'h1);
        chk("st_still_blocked", ready_in, 0);
        ready_out = 1'b1;
        #1;
        chk("st_retire_ready", ready_in, 1);
        step();
        chk("st_done_valid", valid_out, 0);
        chk("st_done_busy", busy, 1);
        drain();

        // Pending limit, resume after one ack, and req+ack together.
        ready_out = 1'b1;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            set_vec(vt[0], TW'(k));
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        chk("lim_hold", mem_req_valid, 0);
        chk("lim_busy", busy, 1);
        chk("lim_out_proceeds", valid_out, 1);
        step();
        chk("lim_ready_in", ready_in, 0);
        chk("lim_still_hold", mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        chk("lim_resume", mem_req_valid, 1);
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        valid_in = 1'b1;
        step();
        chk("lim_after_simul", mem_req_valid, 1);
        step();
        valid_in = 1'b0;
        chk("lim_full_again", mem_req_valid, 0);
        drain();

        // Asynchronous reset with three writes outstanding.
        ready_out = 1'b1;
        mem_req_ready = 1'b1;
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) step();
        valid_in = 1'b0;
        step();
        valid_in = 1'b1;
        mem_req_ready = 1'b0;
        ready_out = 1'b0;
        step();
        valid_in = 1'b0;
        chk("ar_pre_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_mem_req_valid", mem_req_valid, 0);
        chk("ar_valid_out", valid_out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready_in", ready_in, 1);
        mq.delete();
        oq.delete();
        pend = 0;
        reset = 1'b1;
        step();

        for (int n = 0; n < 400; n++) begin
            valid_in = ($urandom_range(0, 9) < 7);
            tag_in = TW'($urandom);
            mask_in = NL'($urandom);
            pass_in = NL'($urandom);
            face_in = NL'($urandom);
            dcrs.depth_writemask = 1'($urandom);
            for (int f = 0; f < 2; f++) begin
                case ($urandom_range(0, 3))
                    0: dcrs.stencil_writemask[f] = 8'h00;
                    1: dcrs.stencil_writemask[f] = 8'hFF;
                    2: dcrs.stencil_writemask[f] =
                           8'h01 << $urandom_range(0, 7);
                    default: dcrs.stencil_writemask[f] = 8'($urandom);
                endcase
            end
            for (int i = 0; i < NL; i++) begin
                depth_in[i]   = 24'($urandom);
                stencil_in[i] = 8'($urandom);
                addr_in[i]    = AW'($urandom);
            end
            ready_out     = ($urandom_range(0, 9) < 7);
            mem_req_ready = ($urandom_range(0, 9) < 7);
            mem_rsp_valid = (pend > 0) && ($urandom_range(0, 9) < 4);
            step();
        end
        valid_in = 1'b0;
        drain();
        chk("rnd_mem_all_seen", mq.size(), 0);
        chk("rnd_out_all_seen", oq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
